traffic_phase_ctrl: RTL

Two-road traffic-light phase sequencer: main road and side road.
- Consumes the 1-second tick produced by the seconds counter upstream (its `last` pulse).
- Drives the red/yellow/green lamps for both roads.
- Exports remaining phase seconds to the display stage downstream.
- Holds a loadable per-phase countdown and a flashing-yellow maintenance mode.

---
 rtl/traffic_pkg.sv | 69 ++++++
 rtl/traffic_phase_ctrl_timer.sv | 33 +++
 rtl/traffic_phase_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic phase controller: state codes, lamp codes,
// the seconds width and small decode helpers.
package traffic_pkg;

  localparam int unsigned SEC_W   = 7;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned LAMP_W  = 3;

  localparam logic [STATE_W-1:0] S_ALL_RED_A_CODE = 3'd0;
  localparam logic [STATE_W-1:0] S_MAIN_GREEN_CODE = 3'd1;
  localparam logic [STATE_W-1:0] S_MAIN_YELLOW_CODE = 3'd2;
  localparam logic [STATE_W-1:0] S_ALL_RED_B_CODE = 3'd3;
  localparam logic [STATE_W-1:0] S_SIDE_GREEN_CODE = 3'd4;
  localparam logic [STATE_W-1:0] S_SIDE_YELLOW_CODE = 3'd5;
  localparam logic [STATE_W-1:0] S_FLASH_CODE = 3'd6;

  // Lamp codes are {red,yellow,green}
  localparam logic [LAMP_W-1:0] LAMP_RED = 3'b100;
  localparam logic [LAMP_W-1:0] LAMP_YEL = 3'b010;
  localparam logic [LAMP_W-1:0] LAMP_GRN = 3'b001;
  localparam logic [LAMP_W-1:0] LAMP_OFF = 3'b000;

  typedef enum logic [STATE_W-1:0] {
    ST_ALL_RED_A  = S_ALL_RED_A_CODE,
    ST_MAIN_GREEN = S_MAIN_GREEN_CODE,
    ST_MAIN_YELLOW = S_MAIN_YELLOW_CODE,
    ST_ALL_RED_B  = S_ALL_RED_B_CODE,
    ST_SIDE_GREEN = S_SIDE_GREEN_CODE,
    ST_SIDE_YELLOW = S_SIDE_YELLOW_CODE,
    ST_FLASH      = S_FLASH_CODE
  } state_e;

  typedef struct packed {
    logic [LAMP_W-1:0] main_l;
    logic [LAMP_W-1:0] side_l;
  } lamps_t;

  // Normal phase rotation; FLASH is left only through the enable path
  function automatic state_e next_phase(input state_e s);
    case (s)
      ST_ALL_RED_A:   return ST_MAIN_GREEN;
      ST_MAIN_GREEN:  return ST_MAIN_YELLOW;
      ST_MAIN_YELLOW: return ST_ALL_RED_B;
      ST_ALL_RED_B:   return ST_SIDE_GREEN;
      ST_SIDE_GREEN:  return ST_SIDE_YELLOW;
      default:        return ST_ALL_RED_A;
    endcase
  endfunction

  // Lamp pattern for a state; blink only matters in FLASH
  function automatic lamps_t lamp_decode(input state_e s, input logic blink);
    lamps_t l;
    l.main_l = LAMP_RED;
    l.side_l = LAMP_RED;
    case (s)
      ST_MAIN_GREEN:  l.main_l = LAMP_GRN;
      ST_MAIN_YELLOW: l.main_l = LAMP_YEL;
      ST_SIDE_GREEN:  l.side_l = LAMP_GRN;
      ST_SIDE_YELLOW: l.side_l = LAMP_YEL;
      ST_FLASH: begin
        l.main_l = blink ? LAMP_YEL : LAMP_OFF;
        l.side_l = blink ? LAMP_YEL : LAMP_OFF;
      end
      default: ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_phase_ctrl_timer.sv
// phase_timer: loadable down-counter holding the seconds left in a phase.
// Load wins over tick; the count saturates at zero.
module phase_timer
  import traffic_pkg::*;
#(
  parameter logic [SEC_W-1:0] pRESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [SEC_W-1:0] i_value,
  input  logic             i_tick,
  output logic [SEC_W-1:0] o_count,
  output logic             o_zero_c
);

  logic [SEC_W-1:0] r_count;

  // Countdown register: load, else decrement on tick while non-zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= pRESET_VAL;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (i_tick && (r_count != '0)) begin
      r_count <= r_count - SEC_W'(1);
    end
  end

  assign o_count  = r_count;
  assign o_zero_c = (r_count == '0);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: two-road phase sequencer with flashing-yellow mode.
// Optional pedestrian shortening of main green is built when PED_REQ_EN is defined.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned pGREEN_MAIN = 30,
  parameter int unsigned pGREEN_SIDE = 20,
  parameter int unsigned pYELLOW     = 3,
  parameter int unsigned pALL_RED    = 2,
  parameter int unsigned pPED_CUT    = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sec_tick,
  input  logic              en,
  input  logic              ped_req,
  output logic [LAMP_W-1:0] main_light,
  output logic [LAMP_W-1:0] side_light,
  output logic [SEC_W-1:0]  remain,
  output logic              phase_end,
  output logic              ped_wait
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_blink;
  logic             w_blink_nxt;
  lamps_t           r_lamps;
  logic             w_load;
  logic [SEC_W-1:0] w_load_val;
  logic             w_tick;
  logic [SEC_W-1:0] w_count;
  logic             w_zero;
  logic             w_cut;

  // Reload value (duration-1) for each timed phase
  function automatic logic [SEC_W-1:0] phase_load(input state_e s);
    case (s)
      ST_ALL_RED_A, ST_ALL_RED_B:     return SEC_W'(pALL_RED - 1);
      ST_MAIN_GREEN:                  return SEC_W'(pGREEN_MAIN - 1);
      ST_SIDE_GREEN:                  return SEC_W'(pGREEN_SIDE - 1);
      ST_MAIN_YELLOW, ST_SIDE_YELLOW: return SEC_W'(pYELLOW - 1);
      default:                        return '0;
    endcase
  endfunction

  phase_timer #(
    .pRESET_VAL(SEC_W'(pALL_RED - 1))
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_load),
    .i_value  (w_load_val),
    .i_tick   (w_tick),
    .o_count  (w_count),
    .o_zero_c (w_zero)
  );

  // Next state, blink and timer control; flash request outranks any advance
  always_comb begin
    w_state_nxt = r_state;
    w_blink_nxt = r_blink;
    w_load      = 1'b0;
    w_load_val  = '0;
    w_tick      = 1'b0;
    if (!en) begin
      if (r_state != ST_FLASH) begin
        w_state_nxt = ST_FLASH;
        w_load      = 1'b1;
        w_blink_nxt = 1'b0;
      end else if (sec_tick) begin
        w_blink_nxt = ~r_blink;
      end
    end else if (r_state == ST_FLASH) begin
      w_state_nxt = ST_ALL_RED_A;
      w_load      = 1'b1;
      w_load_val  = phase_load(ST_ALL_RED_A);
      w_blink_nxt = 1'b0;
    end else if (w_cut) begin
      w_load     = 1'b1;
      w_load_val = SEC_W'(pPED_CUT - 1);
    end else if (sec_tick) begin
      if (w_zero) begin
        w_state_nxt = next_phase(r_state);
        w_load      = 1'b1;
        w_load_val  = phase_load(w_state_nxt);
      end else begin
        w_tick = 1'b1;
      end
    end
  end

  // State, blink and lamp registers; lamps decode the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_ALL_RED_A;
      r_blink        <= 1'b0;
      r_lamps.main_l <= LAMP_RED;
      r_lamps.side_l <= LAMP_RED;
    end else begin
      r_state <= w_state_nxt;
      r_blink <= w_blink_nxt;
      r_lamps <= lamp_decode(w_state_nxt, w_blink_nxt);
    end
  end

`ifdef PED_REQ_EN
  logic r_pend;
  logic w_pend_eff;
  logic w_pend_nxt;

  // Pending request including this clk's button; decides the green cut
  always_comb begin
    w_pend_eff = r_pend;
    if (ped_req && (r_state != ST_SIDE_GREEN) && (r_state != ST_FLASH)) begin
      w_pend_eff = 1'b1;
    end
    w_cut = en && (r_state == ST_MAIN_GREEN) && w_pend_eff &&
            (w_count > SEC_W'(pPED_CUT - 1));
  end

  // Pending clears when the side road gets green or flash mode starts
  always_comb begin
    w_pend_nxt = w_pend_eff;
    if ((w_state_nxt == ST_FLASH) ||
        ((w_state_nxt == ST_SIDE_GREEN) && (r_state != ST_SIDE_GREEN))) begin
      w_pend_nxt = 1'b0;
    end
  end

  // Pedestrian pending register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
    end
  end

  assign ped_wait = r_pend;
`else
  logic [SEC_W:0] w_unused_ped;

  assign w_unused_ped = {ped_req, SEC_W'(pPED_CUT)};
  assign w_cut        = 1'b0;
  assign ped_wait     = 1'b0;
`endif

  assign main_light = r_lamps.main_l;
  assign side_light = r_lamps.side_l;
  assign remain     = w_count;
  assign phase_end  = w_zero && (r_state != ST_FLASH);

endmodule
